scan_mux_reg: RTL
=================

// Module: scan_mux_reg
// PURPOSE
//  Parametrised, registered N-channel selector; successor to the 3-input/2-bit-select registered mux.
//  Generalised to CHANNELS inputs of WIDTH bits each.
//  Adds an auto-scan mode that round-robins the channels on a programmable dwell.
//  Adds valid/channel-tag outputs and an out-of-range select error.
//  Sits between the lab input switches/stimulus and downstream display/compare logic.
// PARAMETERS
//  WIDTH     1   bits per channel
//  CHANNELS  4   number of input channels (>=2)
//  SEL_W     2   select width; must satisfy 2**SEL_W >= CHANNELS
//  DWELL     3   scan mode: clock cycles per channel (>=1)
// PORTS
//  Clk            in   1                 rising-edge clock
//  async_reset_n  in   1                 asynchronous, active-low reset
//  data_in        in   CHANNELS*WIDTH    channel k = data_in[k*WIDTH +: WIDTH]
//  sel            in   SEL_W             manual-mode channel select
//  mode           in   1                 0 = MANUAL, 1 = SCAN
//  en             in   1                 1 = operate; 0 = freeze all state
//  T              out  WIDTH             registered selected data
//  T_valid        out  1                 1-cycle pulse: T updated this cycle
//  T_chan         out  SEL_W             channel index captured into T
//  sel_err        out  1                 1-cycle pulse: manual sel >= CHANNELS
// BEHAVIOUR
//  Reset: async_reset_n=0 clears immediately, no clock needed: T=0, T_valid=0, T_chan=0, sel_err=0.
//   Also clears scan_ptr=0, dwell_cnt=0, state=IDLE. Deassertion is sampled on the next Clk edge.
//  FSM states IDLE, MANUAL, SCAN; state is registered.
//   From any state: en=0 -> IDLE.
//   en=1 & mode=0 -> MANUAL.
//   en=1 & mode=1 -> SCAN.
//  IDLE:
//   T and T_chan hold their values; T_valid=0; sel_err=0.
//   scan_ptr and dwell_cnt are frozen, not cleared.
//  MANUAL (1-cycle latency):
//   Each edge with en=1, mode=0, sel<CHANNELS: T<=ch[sel], T_chan<=sel, T_valid<=1.
//   If sel>=CHANNELS: T and T_chan hold, T_valid<=0, sel_err<=1.
//   Sampling is continuous: T_valid stays high on every valid cycle.
//  SCAN:
//   On entering SCAN from MANUAL, the transition edge loads dwell_cnt=0 and scan_ptr=0.
//   From IDLE, the scan resumes with the frozen values.
//   dwell_cnt increments each enabled edge.
//   When dwell_cnt==DWELL-1: T<=ch[scan_ptr], T_chan<=scan_ptr, T_valid<=1, dwell_cnt<=0.
//    scan_ptr then increments, wrapping CHANNELS-1 -> 0.
//   Otherwise T_valid<=0.
//   DWELL=1 samples every cycle.
//   sel is ignored in SCAN; sel_err=0.
//  Mode change mid-dwell: takes effect on that edge; no sample is produced for the abandoned dwell.
//  Width rules:
//   scan_ptr is SEL_W bits; dwell_cnt is $clog2(DWELL+1) bits.
//   Comparisons are unsigned; no truncation of T.
// CONFIGURATION
//  SCAN_MUX_PARITY_EN defined:
//   Adds output T_par (1 bit) = even parity (XOR-reduce) of the value loaded into T.
//   Registered with T; reset 0; holds whenever T holds.
//  SCAN_MUX_PARITY_EN undefined: port T_par and its logic are absent.
// TESTING (WIDTH=1, CHANNELS=3, SEL_W=2, DWELL=3, 18 ns clock)
//  1. Reset: async_reset_n=0 between edges -> T=0, T_valid=0, T_chan=0 immediately, before the next edge.
//  2. MANUAL: data_in=3'b101, en=1, sel=0,1,2 on successive edges -> T=1,0,1, T_chan=0,1,2, T_valid=1 each.
//  3. Bad select: MANUAL, sel=3 -> sel_err=1 for 1 cycle, T and T_chan unchanged, T_valid=0.
//  4. SCAN: mode=1, data_in=3'b110 -> T_valid every 3rd edge.
//     T_chan sequence 0,1,2,0; T sequence 0,1,1,0.
//  5. Freeze: en=0 for 5 cycles mid-dwell (dwell_cnt=1) -> no T_valid; after en=1, next sample after 2 edges.
//     Sample is on the same scan_ptr as before the freeze.
//  6. Reset mid-scan: async_reset_n=0 at scan_ptr=2 -> all outputs 0.
//     After release with mode=1, first sample is channel 0 after 3 edges.
//     With SCAN_MUX_PARITY_EN, also check T_par tracks T.

Source files
------------

// File: rtl/scan_mux_reg_if.sv
// scan_mux_reg_if: channel inputs, controls and registered outputs.
// master drives inputs; slave is the selector.
//   data_in  CHANNELS*WIDTH  packed channel data, ch k at [k*WIDTH +: WIDTH]
//   sel      SEL_W           manual select
//   mode     1               0 manual, 1 scan
//   en       1               operate / freeze
//   T        WIDTH           registered selected data
//   T_valid  1               T updated this cycle
//   T_chan   SEL_W           channel captured into T
//   sel_err  1               manual sel out of range
//   T_par    1               parity of T (SCAN_MUX_PARITY_EN only)
interface scan_mux_reg_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      en;
  logic [WIDTH-1:0]          T;
  logic                      T_valid;
  logic [SEL_W-1:0]          T_chan;
  logic                      sel_err;
`ifdef SCAN_MUX_PARITY_EN
  logic                      T_par;

  modport master (
    output data_in, sel, mode, en,
    input  T, T_valid, T_chan, sel_err, T_par
  );
  modport slave (
    input  data_in, sel, mode, en,
    output T, T_valid, T_chan, sel_err, T_par
  );
`else
  modport master (
    output data_in, sel, mode, en,
    input  T, T_valid, T_chan, sel_err
  );
  modport slave (
    input  data_in, sel, mode, en,
    output T, T_valid, T_chan, sel_err
  );
`endif
endinterface

// File: rtl/scan_mux_reg.sv
// scan_mux_reg: registered N-channel selector, manual or auto-scan.
// Ports: Clk, async_reset_n (async, active-low), bus (scan_mux_reg_if.slave).
// Option SCAN_MUX_PARITY_EN adds T_par, even parity of T.
module scan_mux_reg #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 3
) (
  input logic          Clk,
  input logic          async_reset_n,
  scan_mux_reg_if.slave bus
);

  localparam int NSLOT = 2 ** SEL_W;
  localparam int DW    = $clog2(DWELL + 1);

  localparam logic [DW-1:0]    DLAST = DW'(DWELL - 1);
  localparam logic [SEL_W-1:0] PLAST = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             t_valid_q, t_valid_d;
  logic [SEL_W-1:0] t_chan_q, t_chan_d;
  logic             sel_err_q, sel_err_d;
  logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [DW-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic             t_par_q, t_par_d;

  // Pad to a power of two so any sel value indexes in range.
  logic [WIDTH-1:0] ch [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_ch
    if (g < CHANNELS) begin : g_in
      assign ch[g] = bus.data_in[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[g] = '0;
    end
  end

  logic sel_ok;
  assign sel_ok = 32'(bus.sel) < CHANNELS;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    t_valid_d   = 1'b0;
    t_chan_d    = t_chan_q;
    sel_err_d   = 1'b0;
    scan_ptr_d  = scan_ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    t_par_d     = t_par_q;
    unique case (1'b1)
      !bus.en: begin
        state_d = IDLE;
      end
      bus.en && !bus.mode: begin
        state_d = MANUAL;
        if (sel_ok) begin
          t_d       = ch[bus.sel];
          t_chan_d  = bus.sel;
          t_valid_d = 1'b1;
          t_par_d   = ^ch[bus.sel];
        end else begin
          sel_err_d = 1'b1;
        end
      end
      bus.en && bus.mode: begin
        state_d = SCAN;
        // Leaving manual restarts the scan; idle resumes it.
        if (state_q == MANUAL) begin
          scan_ptr_d  = '0;
          dwell_cnt_d = '0;
        end else if (dwell_cnt_q == DLAST) begin
          t_d         = ch[scan_ptr_q];
          t_chan_d    = scan_ptr_q;
          t_valid_d   = 1'b1;
          t_par_d     = ^ch[scan_ptr_q];
          dwell_cnt_d = '0;
          scan_ptr_d  = (scan_ptr_q == PLAST) ? '0
                      : scan_ptr_q + SEL_W'(1);
        end else begin
          dwell_cnt_d = dwell_cnt_q + DW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      t_valid_q   <= 1'b0;
      t_chan_q    <= '0;
      sel_err_q   <= 1'b0;
      scan_ptr_q  <= '0;
      dwell_cnt_q <= '0;
      t_par_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      t_valid_q   <= t_valid_d;
      t_chan_q    <= t_chan_d;
      sel_err_q   <= sel_err_d;
      scan_ptr_q  <= scan_ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      t_par_q     <= t_par_d;
    end
  end

  assign bus.T       = t_q;
  assign bus.T_valid = t_valid_q;
  assign bus.T_chan  = t_chan_q;
  assign bus.sel_err = sel_err_q;

`ifdef SCAN_MUX_PARITY_EN
  assign bus.T_par = t_par_q;
`else
  logic unused_par;
  assign unused_par = t_par_q;
`endif

endmodule
